// File: rtl/irda_sir_demod.sv
// irda_sir_demod -- IrDA SIR (up to 115.2 kbit/s) receive demodulator.
//
// Converts the return-to-zero IR pulse stream on rx_i into an NRZ bit stream.
// Each bit period is a window of OVERSAMPLE sample_en ticks. If a qualified
// pulse falls inside a window, the window decodes as 0. Otherwise it decodes
// as 1.
//
// Optional feature macro: IRDA_SIR_DEMOD_ALIGN_EN
//   defined   : IDLE/RUN aligner. Windows resynchronise to the first pulse of
//               each frame. After IDLE_BITS consecutive 1s, the aligner
//               returns to IDLE.
//   undefined : no aligner. The window counter free-runs from reset and
//               aligned_o is tied to 1.
//
// Ports
//   clk         : clock
//   wb_rst_i    : asynchronous active-high reset
//   rx_i        : raw IR receive input (asynchronous)
//   sample_en   : one-clk oversample tick at OVERSAMPLE x baud
//   tx_select   : half-duplex transmit active; freezes the receiver
//   fast_mode   : MIR/FIR selected; synchronous clear of the whole block
//   err_clr_i   : clears pulse_err_o
//   bit_o       : decoded NRZ bit
//   bit_vld_o   : one-clk strobe when bit_o is updated
//   pulse_err_o : sticky flag, a pulse exceeded MAX_PULSE samples
//   aligned_o   : aligner is in RUN state
module irda_sir_demod #(
   parameter int unsigned OVERSAMPLE     = 16,
   parameter int unsigned MIN_PULSE      = 2,
   parameter int unsigned MAX_PULSE      = 8,
   parameter int unsigned IDLE_BITS      = 10,
   parameter int unsigned RX_ACTIVE_HIGH = 1
) (
   input  logic clk,
   input  logic wb_rst_i,
   input  logic rx_i,
   input  logic sample_en,
   input  logic tx_select,
   input  logic fast_mode,
   input  logic err_clr_i,
   output logic bit_o,
   output logic bit_vld_o,
   output logic pulse_err_o,
   output logic aligned_o
);

   localparam int unsigned CNT_W  = $clog2(OVERSAMPLE);
   localparam int unsigned RUN_W  = $clog2(MAX_PULSE + 2);
   localparam int unsigned ONES_W = $clog2(IDLE_BITS + 1);

   // Without the aligner, the state register is held in RUN and the IDLE
   // transition logic folds away as constant.
`ifdef IRDA_SIR_DEMOD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   // Synchroniser reset value is the inactive line level.
   localparam logic RX_IDLE = (RX_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

   typedef enum logic {S_IDLE, S_RUN} state_t;
   localparam state_t ST_RST = ALIGN ? S_IDLE : S_RUN;

   logic [1:0]        sync_q;
   logic [RUN_W-1:0]  run_q,   run_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ONES_W-1:0] ones_q,  ones_d;
   logic              zero_q,  zero_d;
   logic              err_q,   err_d;
   logic              bit_q,   bit_d;
   logic              vld_q,   vld_d;
   state_t            state_q, state_d;

   logic act, adv, qual, err_set, boundary, emit;

   assign act      = (RX_ACTIVE_HIGH != 0) ? sync_q[1] : ~sync_q[1];
   assign adv      = sample_en & ~tx_select;
   assign qual     = adv & act & (run_q == RUN_W'(MIN_PULSE - 1));
   // Re-asserted on every sample spent at saturation, so set beats a
   // coincident clear for as long as the over-long pulse persists.
   assign err_set  = adv & act & (run_q >= RUN_W'(MAX_PULSE));
   assign boundary = (cnt_q == CNT_W'(OVERSAMPLE - 1));
   // A qual on the boundary sample belongs to the window that is closing.
   assign emit     = ~(zero_q | qual);

   always_comb begin
      run_d   = run_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      zero_d  = zero_q;
      err_d   = err_q;
      bit_d   = bit_q;
      vld_d   = 1'b0;
      state_d = state_q;

      if (tx_select) begin
         run_d = '0;
      end else if (sample_en) begin
         if (!act)
            run_d = '0;
         else if (run_q != RUN_W'(MAX_PULSE + 1))
            run_d = run_q + RUN_W'(1);
      end

      if (err_set)
         err_d = 1'b1;
      else if (err_clr_i)
         err_d = 1'b0;

      if (adv) begin
         if (state_q == S_IDLE) begin
            // The pulse began MIN_PULSE-1 samples ago. That first sample is
            // window position 0, so the next sample is position MIN_PULSE.
            if (qual) begin
               state_d = S_RUN;
               cnt_d   = CNT_W'(MIN_PULSE);
               zero_d  = 1'b1;
            end
         end else if (boundary) begin
            bit_d  = emit;
            vld_d  = 1'b1;
            zero_d = 1'b0;
            cnt_d  = '0;
            if (!emit) begin
               ones_d = '0;
            end else if (ones_q == ONES_W'(IDLE_BITS - 1)) begin
               ones_d = '0;
               if (ALIGN)
                  state_d = S_IDLE;
            end else begin
               ones_d = ones_q + ONES_W'(1);
            end
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            zero_d = zero_q | qual;
         end
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync_q  <= {2{RX_IDLE}};
         run_q   <= '0;
         cnt_q   <= '0;
         ones_q  <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
         bit_q   <= 1'b1;
         vld_q   <= 1'b0;
         state_q <= ST_RST;
      end else if (fast_mode) begin
         sync_q  <= {2{RX_IDLE}};
         run_q   <= '0;
         cnt_q   <= '0;
         ones_q  <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
         bit_q   <= 1'b1;
         vld_q   <= 1'b0;
         state_q <= ST_RST;
      end else begin
         sync_q  <= {sync_q[0], rx_i};
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
         bit_q   <= bit_d;
         vld_q   <= vld_d;
         state_q <= state_d;
      end
   end

   assign bit_o       = bit_q;
   assign bit_vld_o   = vld_q;
   assign pulse_err_o = err_q;
   assign aligned_o   = (state_q == S_RUN);

endmodule

// File: tb/tb_irda_sir_demod.sv
// Testbench for irda_sir_demod. Expected decoded bits are queued when the
// stimulus is issued. A monitor pops and compares one entry on every
// bit_vld_o strobe. Works with IRDA_SIR_DEMOD_ALIGN_EN defined or undefined.
module tb_irda_sir_demod;

`ifdef IRDA_SIR_DEMOD_ALIGN_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clk = 1'b0;
   logic wb_rst_i, rx_i, sample_en, tx_select, fast_mode, err_clr_i;
   logic bit_o, bit_vld_o, pulse_err_o, aligned_o;

   int errors   = 0;
   int checks   = 0;
   int n_strobe = 0;
   int mark;
   bit exp_q[$];

   always #5 clk = ~clk;

   irda_sir_demod #(
      .OVERSAMPLE(16),
      .MIN_PULSE(2),
      .MAX_PULSE(8),
      .IDLE_BITS(10),
      .RX_ACTIVE_HIGH(1)
   ) dut (
      .clk(clk),
      .wb_rst_i(wb_rst_i),
      .rx_i(rx_i),
      .sample_en(sample_en),
      .tx_select(tx_select),
      .fast_mode(fast_mode),
      .err_clr_i(err_clr_i),
      .bit_o(bit_o),
      .bit_vld_o(bit_vld_o),
      .pulse_err_o(pulse_err_o),
      .aligned_o(aligned_o)
   );

   task automatic chk(input string name, input logic actual, input logic expv);
      checks++;
      if (actual !== expv) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, actual, expv);
      end
   endtask

   task automatic chk_int(input string name, input int actual, input int expv);
      checks++;
      if (actual != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expv);
      end
   endtask

   // Monitor: every strobe consumes one expected bit.
   always @(negedge clk) begin
      if (bit_vld_o === 1'b1) begin
         n_strobe++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_unexpected: got strobe bit=%b expected no strobe", bit_o);
         end else begin
            chk("strobe_bit", bit_o, exp_q.pop_front());
         end
      end
   end

   // One oversample: rx is driven 4 clk ahead of the sample edge, so the
   // 2-flop synchroniser has settled by the time sample_en is seen.
   task automatic smp(input logic rx, input logic clr);
      rx_i = rx;
      repeat (3) @(negedge clk);
      sample_en = 1'b1;
      err_clr_i = clr;
      @(negedge clk);
      sample_en = 1'b0;
      err_clr_i = 1'b0;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) smp(1'b0, 1'b0);
   endtask

   task automatic pulse(input int n);
      for (int i = 0; i < n; i++) smp(1'b1, 1'b0);
   endtask

   task automatic push(input bit b, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(b);
   endtask

   initial begin
      wb_rst_i  = 1'b1;
      rx_i      = 1'b0;
      sample_en = 1'b0;
      tx_select = 1'b0;
      fast_mode = 1'b0;
      err_clr_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bit", bit_o, 1'b1);
      chk("rst_vld", bit_vld_o, 1'b0);
      chk("rst_err", pulse_err_o, 1'b0);
      chk("rst_aligned", aligned_o, !ALIGN);
      wb_rst_i = 1'b0;
      #1;

      // A: 3-sample pulse, then idle. One 0, then ten 1s (aligner) or 15 1s.
      mark = n_strobe;
      push(1'b0, 1);
      push(1'b1, ALIGN ? 10 : 15);
      idle(2);
      pulse(3);
      chk("A_aligned_after_pulse", aligned_o, 1'b1);
      idle(251);
      chk_int("A_strobe_count", n_strobe - mark, ALIGN ? 11 : 16);
      chk("A_aligned_end", aligned_o, !ALIGN);

      // B: 1-sample glitch is ignored.
      mark = n_strobe;
      if (!ALIGN) push(1'b1, 2);
      idle(5);
      pulse(1);
      idle(26);
      chk_int("B_strobe_count", n_strobe - mark, ALIGN ? 0 : 2);
      chk("B_aligned", aligned_o, !ALIGN);

      // C: over-long pulse, sticky error, set beats clear.
      mark = n_strobe;
      push(1'b0, 1);
      push(1'b1, 10);
      pulse(8);
      chk("C_err_before_max", pulse_err_o, 1'b0);
      smp(1'b1, 1'b0);
      chk("C_err_set", pulse_err_o, 1'b1);
      smp(1'b1, 1'b1);
      chk("C_set_wins", pulse_err_o, 1'b1);
      smp(1'b0, 1'b1);
      chk("C_err_cleared", pulse_err_o, 1'b0);
      idle(165);
      chk_int("C_strobe_count", n_strobe - mark, 11);
      chk("C_aligned_end", aligned_o, !ALIGN);

      // D: second pulse qualifies on the window's last sample.
      mark = n_strobe;
      push(1'b0, 2);
      push(1'b1, 10);
      pulse(2);
      idle(28);
      pulse(2);
      chk_int("D_boundary_strobes", n_strobe - mark, 2);
      idle(160);
      chk_int("D_strobe_count", n_strobe - mark, 12);
      chk("D_aligned_end", aligned_o, !ALIGN);

      // E: tx_select freezes the window mid-frame.
      push(1'b0, 1);
      push(1'b1, 10);
      pulse(2);
      idle(6);
      tx_select = 1'b1;
      mark = n_strobe;
      for (int i = 0; i < 40; i++) smp((i % 5) < 3, 1'b0);
      chk_int("E_no_strobe_tx", n_strobe - mark, 0);
      chk("E_aligned_tx", aligned_o, 1'b1);
      tx_select = 1'b0;
      idle(7);
      chk_int("E_resume_early", n_strobe - mark, 0);
      idle(1);
      chk_int("E_resume_strobe", n_strobe - mark, 1);
      idle(160);
      chk_int("E_strobe_count", n_strobe - mark, 11);

      // F1: asynchronous reset mid-window.
      push(1'b0, 1);
      pulse(9);
      idle(7);
      chk("F_err_before_rst", pulse_err_o, 1'b1);
      chk("F_bit_before_rst", bit_o, 1'b0);
      idle(5);
      wb_rst_i = 1'b1;
      #1;
      chk("F_rst_bit", bit_o, 1'b1);
      chk("F_rst_vld", bit_vld_o, 1'b0);
      chk("F_rst_err", pulse_err_o, 1'b0);
      chk("F_rst_aligned", aligned_o, !ALIGN);
      repeat (2) @(negedge clk);
      wb_rst_i = 1'b0;
      #1;
      mark = n_strobe;
      if (!ALIGN) push(1'b1, 1);
      idle(15);
      chk_int("F_rst_no_early_strobe", n_strobe - mark, 0);
      idle(1);
      chk_int("F_rst_first_strobe", n_strobe - mark, ALIGN ? 0 : 1);

      // F2: fast_mode clears everything synchronously.
      push(1'b0, 1);
      pulse(9);
      idle(7);
      chk("G_err_before_fast", pulse_err_o, 1'b1);
      chk("G_bit_before_fast", bit_o, 1'b0);
      idle(3);
      @(negedge clk);
      fast_mode = 1'b1;
      @(negedge clk);
      fast_mode = 1'b0;
      #1;
      chk("G_fast_bit", bit_o, 1'b1);
      chk("G_fast_vld", bit_vld_o, 1'b0);
      chk("G_fast_err", pulse_err_o, 1'b0);
      chk("G_fast_aligned", aligned_o, !ALIGN);
      mark = n_strobe;
      if (!ALIGN) push(1'b1, 1);
      idle(15);
      chk_int("G_fast_no_early_strobe", n_strobe - mark, 0);
      idle(1);
      chk_int("G_fast_first_strobe", n_strobe - mark, ALIGN ? 0 : 1);
      push(1'b0, 1);
      pulse(2);
      idle(14);
      chk_int("G_after_pulse_strobe", n_strobe - mark, ALIGN ? 1 : 2);

      repeat (8) @(negedge clk);
      chk_int("leftover_expected_bits", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
